// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and a
// default operand width for benches.
package sub_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor: d = x - y - bin, bout set when the bit underflows.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first,
// built from a single fs_cell and a borrow flip-flop.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa, sb, pr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d, bout;

  fs_cell u_fs (
    .x   (sa[0]),
    .y   (sb[0]),
    .bin (br),
    .d   (d),
    .bout(bout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      sa         <= '0;
      sb         <= '0;
      pr         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        // DONE accepts a new request exactly like IDLE, so ops can run back to back
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= borrow_in;
            pr    <= '0;
            cnt   <= '0;
            state <= S_SHIFT;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_SHIFT: begin
          br  <= bout;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          pr  <= {d, pr[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          // Last bit: publish the completed word directly, bypassing pr
          if (cnt == LAST) begin
            diff       <= {d, pr[WIDTH-1:1]};
            borrow_out <= bout;
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
